// File: rtl/aclk_pkg.sv
// Shared types and constants for the alarm-clock keypad controller.
package aclk_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME  = 3'd0,
    KEY_STORED = 3'd1,
    KEY_WAITED = 3'd2,
    KEY_ENTRY  = 3'd3,
    SHOW_ALARM = 3'd4
  } state_t;

  localparam logic [3:0] KEY_ALARM_C = 4'd10;
  localparam logic [3:0] KEY_TIME_C  = 4'd11;
  localparam logic [3:0] KEY_NONE_C  = 4'd15;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/aclk_timeout_cnt.sv
// Entry-abandon counter: counts one_second ticks while enabled, flags the last one.
module aclk_timeout_cnt #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic done
);

  localparam logic [3:0] LAST = 4'(TIMEOUT_SEC - 1);

  logic [3:0] count;

  assign done = enable & tick & (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || done) begin
      count <= 4'd0;
    end else if (enable && tick) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/aclk_controller.sv
// Keypad sequencing FSM: digit entry, alarm/current-time commit, alarm display.
//   state      | meaning
//   SHOW_TIME  | idle, display current time
//   KEY_STORED | one-cycle shift of the pressed digit
//   KEY_WAITED | waiting for the digit key to be released
//   KEY_ENTRY  | waiting for next digit or ALARM/TIME commit
//   SHOW_ALARM | display alarm time while ALARM is held
module aclk_controller
  import aclk_pkg::*;
#(
  parameter int         TIMEOUT_SEC = 10,
  parameter logic [3:0] KEY_ALARM   = KEY_ALARM_C,
  parameter logic [3:0] KEY_TIME    = KEY_TIME_C,
  parameter logic [3:0] KEY_NONE    = KEY_NONE_C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic       one_second,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       reset_count,
  output logic       show_a,
  output logic       show_new_time
);

  state_t state;
  logic   key_digit, key_alarm, key_time, key_none;
  logic   cnt_clear, cnt_enable, timeout;

  // Codes 12-14 (and KEY_NONE) all behave as "no key".
  assign key_digit = is_digit(key);
  assign key_alarm = (key == KEY_ALARM);
  assign key_time  = (key == KEY_TIME);
  assign key_none  = ~(key_digit | key_alarm | key_time);

  // Counter runs only while an entry is open; a key event in KEY_ENTRY restarts it.
  assign cnt_enable = (state == KEY_WAITED) || (state == KEY_ENTRY);
  assign cnt_clear  = ~cnt_enable || ((state == KEY_ENTRY) && ~key_none);

  aclk_timeout_cnt #(.TIMEOUT_SEC(TIMEOUT_SEC)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .tick   (one_second),
    .done   (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SHOW_TIME;
      shift         <= 1'b0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
      reset_count   <= 1'b0;
      show_a        <= 1'b0;
      show_new_time <= 1'b0;
    end else begin
      shift         <= 1'b0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
      reset_count   <= 1'b0;
      show_a        <= 1'b0;
      show_new_time <= 1'b0;
      case (state)
        SHOW_TIME: begin
          if (key_digit) begin
            state         <= KEY_STORED;
            shift         <= 1'b1;
            show_new_time <= 1'b1;
          end else if (key_alarm) begin
            state  <= SHOW_ALARM;
            show_a <= 1'b1;
          end
        end
        KEY_STORED: begin
          state         <= KEY_WAITED;
          show_new_time <= 1'b1;
        end
        KEY_WAITED: begin
          if (key_none) begin
            state         <= KEY_ENTRY;
            show_new_time <= 1'b1;
          end else if (timeout) begin
            state <= SHOW_TIME;
          end else begin
            show_new_time <= 1'b1;
          end
        end
        KEY_ENTRY: begin
          if (key_digit) begin
            state         <= KEY_STORED;
            shift         <= 1'b1;
            show_new_time <= 1'b1;
          end else if (key_alarm) begin
            state      <= SHOW_TIME;
            load_new_a <= 1'b1;
          end else if (key_time) begin
            state       <= SHOW_TIME;
            load_new_c  <= 1'b1;
            reset_count <= 1'b1;
          end else if (timeout) begin
            state <= SHOW_TIME;
          end else begin
            show_new_time <= 1'b1;
          end
        end
        SHOW_ALARM: begin
          if (key_alarm) begin
            show_a <= 1'b1;
          end else begin
            state <= SHOW_TIME;
          end
        end
        default: state <= SHOW_TIME;
      endcase
    end
  end

endmodule

// File: tb/tb_aclk_controller.sv
// Directed bench for aclk_controller: entry, commit, timeout, alarm display, reset.
module tb_aclk_controller;
  import aclk_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key;
  logic       one_second;
  logic       shift, load_new_a, load_new_c, reset_count, show_a, show_new_time;
  logic [5:0] outs;

  int checks = 0;
  int errors = 0;
  int n_shift, n_snt, n_la, n_lc, n_rc, n_sa;
  int shift_run, rc_mismatch, both_loads;
  logic prev_shift;

  aclk_controller dut (
    .clk           (clk),
    .reset         (reset),
    .key           (key),
    .one_second    (one_second),
    .shift         (shift),
    .load_new_a    (load_new_a),
    .load_new_c    (load_new_c),
    .reset_count   (reset_count),
    .show_a        (show_a),
    .show_new_time (show_new_time)
  );

  always #5 clk = ~clk;

  assign outs = {shift, load_new_a, load_new_c, reset_count, show_a, show_new_time};

  task automatic clr_stats();
    n_shift = 0; n_snt = 0; n_la = 0; n_lc = 0; n_rc = 0; n_sa = 0;
    shift_run = 0; rc_mismatch = 0; both_loads = 0; prev_shift = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      n_shift += int'(shift);
      n_snt   += int'(show_new_time);
      n_la    += int'(load_new_a);
      n_lc    += int'(load_new_c);
      n_rc    += int'(reset_count);
      n_sa    += int'(show_a);
      if (shift && prev_shift) shift_run++;
      if (reset_count !== load_new_c) rc_mismatch++;
      if (load_new_a && load_new_c) both_loads++;
      prev_shift = shift;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key = 4'd15; one_second = 1'b0;
    step(2);
    checks++;
    if (outs !== 6'b0) begin errors++; $display("FAIL reset_outs got %b want 000000", outs); end
    checks++;
    if (dut.state !== SHOW_TIME) begin errors++; $display("FAIL reset_state got %0d want 0", dut.state); end
    checks++;
    if (dut.u_timeout.count !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", dut.u_timeout.count); end
    reset = 1'b0;
    clr_stats();
    step(20);
    checks++;
    if (n_shift + n_snt + n_la + n_lc + n_rc + n_sa != 0) begin
      errors++; $display("FAIL idle_outs got %0d high output-cycles want 0", n_shift + n_snt + n_la + n_lc + n_rc + n_sa);
    end
    checks++;
    if (dut.state !== SHOW_TIME) begin errors++; $display("FAIL idle_state got %0d want 0", dut.state); end
  endtask

  task automatic test_set_alarm();
    clr_stats();
    for (int d = 1; d <= 4; d++) begin
      key = 4'(d); step(3);
      key = 4'd15; step(2);
    end
    key = 4'd10; step(1);
    checks++;
    if (load_new_a !== 1'b1) begin errors++; $display("FAIL alarm_strobe got %b want 1", load_new_a); end
    key = 4'd15; step(1);
    checks++;
    if (show_new_time !== 1'b0) begin errors++; $display("FAIL alarm_snt_after got %b want 0", show_new_time); end
    checks++;
    if (n_shift != 4) begin errors++; $display("FAIL alarm_shifts got %0d want 4", n_shift); end
    checks++;
    if (shift_run != 0) begin errors++; $display("FAIL alarm_shift_width got %0d long pulses want 0", shift_run); end
    checks++;
    if (n_snt != 20) begin errors++; $display("FAIL alarm_snt_cycles got %0d want 20", n_snt); end
    checks++;
    if (n_la != 1 || n_lc != 0) begin errors++; $display("FAIL alarm_loads got a=%0d c=%0d want a=1 c=0", n_la, n_lc); end
  endtask

  task automatic test_set_time();
    logic [3:0] digits [4];
    digits = '{4'd0, 4'd7, 4'd3, 4'd0};
    clr_stats();
    for (int i = 0; i < 4; i++) begin
      key = digits[i]; step(2);
      key = 4'd13; step(2);
    end
    key = 4'd11; step(3);
    key = 4'd15; step(1);
    checks++;
    if (n_shift != 4) begin errors++; $display("FAIL time_shifts got %0d want 4", n_shift); end
    checks++;
    if (n_lc != 1 || n_rc != 1) begin errors++; $display("FAIL time_loads got c=%0d rc=%0d want 1 1", n_lc, n_rc); end
    checks++;
    if (rc_mismatch != 0) begin errors++; $display("FAIL time_rc_coincident got %0d mismatching cycles want 0", rc_mismatch); end
    checks++;
    if (n_la != 0 || both_loads != 0) begin errors++; $display("FAIL time_no_alarm_load got a=%0d both=%0d want 0 0", n_la, both_loads); end
  endtask

  task automatic test_timeout();
    clr_stats();
    key = 4'd5; step(1);
    key = 4'd15; step(2);
    repeat (9) begin one_second = 1'b1; step(1); one_second = 1'b0; step(1); end
    checks++;
    if (dut.u_timeout.count !== 4'd9 || show_new_time !== 1'b1) begin
      errors++; $display("FAIL timeout_9 got cnt=%0d snt=%b want 9 1", dut.u_timeout.count, show_new_time);
    end
    one_second = 1'b1; step(1); one_second = 1'b0;
    checks++;
    if (dut.state !== SHOW_TIME || show_new_time !== 1'b0 || dut.u_timeout.count !== 4'd0) begin
      errors++; $display("FAIL timeout_10 got state=%0d snt=%b cnt=%0d want 0 0 0", dut.state, show_new_time, dut.u_timeout.count);
    end
    checks++;
    if (n_la + n_lc != 0) begin errors++; $display("FAIL timeout_no_load got %0d want 0", n_la + n_lc); end

    key = 4'd5; step(1);
    key = 4'd15; step(2);
    repeat (9) begin one_second = 1'b1; step(1); one_second = 1'b0; step(1); end
    key = 4'd6; step(1);
    checks++;
    if (shift !== 1'b1 || dut.u_timeout.count !== 4'd0) begin
      errors++; $display("FAIL timeout_restart got shift=%b cnt=%0d want 1 0", shift, dut.u_timeout.count);
    end
    key = 4'd15; step(2);
    repeat (9) begin one_second = 1'b1; step(1); one_second = 1'b0; step(1); end
    key = 4'd2; one_second = 1'b1; step(1); one_second = 1'b0;
    checks++;
    if (shift !== 1'b1 || dut.state !== KEY_STORED || dut.u_timeout.count !== 4'd0) begin
      errors++; $display("FAIL digit_vs_timeout got shift=%b state=%0d cnt=%0d want 1 1 0", shift, dut.state, dut.u_timeout.count);
    end
    key = 4'd15; step(2);
    repeat (10) begin one_second = 1'b1; step(1); one_second = 1'b0; step(1); end
    checks++;
    if (dut.state !== SHOW_TIME) begin errors++; $display("FAIL timeout_final got state=%0d want 0", dut.state); end
  endtask

  task automatic test_show_alarm();
    clr_stats();
    key = 4'd10; step(8);
    checks++;
    if (n_sa != 8 || show_a !== 1'b1) begin errors++; $display("FAIL show_a_held got %0d cycles want 8", n_sa); end
    key = 4'd15; step(1);
    checks++;
    if (show_a !== 1'b0) begin errors++; $display("FAIL show_a_release got %b want 0", show_a); end
    key = 4'd10; step(1);
    key = 4'd3; step(1);
    key = 4'd15; step(2);
    checks++;
    if (n_shift != 0 || dut.state !== SHOW_TIME) begin
      errors++; $display("FAIL alarm_exit_digit got shifts=%0d state=%0d want 0 0", n_shift, dut.state);
    end
  endtask

  task automatic test_reset_mid_entry();
    key = 4'd5; step(1);
    one_second = 1'b1; step(1);
    step(1);
    checks++;
    if (dut.state !== KEY_WAITED || dut.u_timeout.count !== 4'd1) begin
      errors++; $display("FAIL pre_reset got state=%0d cnt=%0d want 2 1", dut.state, dut.u_timeout.count);
    end
    reset = 1'b1; step(1);
    checks++;
    if (outs !== 6'b0 || dut.state !== SHOW_TIME || dut.u_timeout.count !== 4'd0) begin
      errors++; $display("FAIL mid_reset got outs=%b state=%0d cnt=%0d want 000000 0 0", outs, dut.state, dut.u_timeout.count);
    end
    reset = 1'b0; one_second = 1'b0; key = 4'd15; step(1);
    checks++;
    if (outs !== 6'b0) begin errors++; $display("FAIL post_reset got %b want 000000", outs); end
  endtask

  initial begin
    test_reset();
    test_set_alarm();
    test_set_time();
    test_timeout();
    test_show_alarm();
    test_reset_mid_entry();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
